// File: rtl/data_path.sv
// Single-cycle ARM-subset datapath: PC, 15x32 register file, immediate extender, ALU, result muxing.
// Optional build macro DATAPATH_ROTIMM_EN: ImmSrc=00 becomes the rotated 8-bit data-processing immediate.
module data_path (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  RegSrc,
  input  logic        RegWrite,
  input  logic [1:0]  ImmSrc,
  input  logic        ALUSrc,
  input  logic [1:0]  ALUControl,
  input  logic        MemtoReg,
  input  logic        PCSrc,
  output logic        Zero,
  output logic        Negative,
  output logic        Overflow,
  output logic        Carry,
  output logic [31:0] PC,
  input  logic [31:0] Instr,
  output logic [31:0] ALUResult,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  localparam int DATA_W = 32;

  logic [DATA_W-1:0] rf [0:14];
  logic [DATA_W-1:0] pc_plus4, pc_plus8, pc_next;
  logic [3:0]        ra1, ra2, wa3;
  logic [DATA_W-1:0] rd1, rd2, ext_imm, src_b, result;
  logic [35:0]       alu_out;
  logic              unused_instr;

  // {N, Z, C, V, result}; C and V are only meaningful for ADD/SUB
  function automatic logic [35:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [1:0] op);
    logic [32:0] sum;
    logic [31:0] r;
    logic        c, v;
    sum = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      2'b00: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[31:0];
        c   = sum[32];
        v   = (a[31] == b[31]) && (r[31] != a[31]);
      end
      2'b01: begin
        sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r   = sum[31:0];
        c   = sum[32];
        v   = (a[31] != b[31]) && (r[31] != a[31]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r[31], (r == 32'h0), c, v, r};
  endfunction

`ifdef DATAPATH_ROTIMM_EN
  // Rotate right by twice the 4-bit field, done as a shift of the doubled word
  function automatic logic [31:0] rot_imm(input logic [11:0] f);
    logic [63:0] d;
    d = {24'b0, f[7:0], 24'b0, f[7:0]} >> {f[11:8], 1'b0};
    return d[31:0];
  endfunction
`endif

  assign pc_plus4 = PC + 32'd4;
  assign pc_plus8 = PC + 32'd8;

  assign ra1 = RegSrc[0] ? 4'hF : Instr[19:16];
  assign ra2 = RegSrc[1] ? Instr[15:12] : Instr[3:0];
  assign wa3 = Instr[15:12];

  assign rd1 = (ra1 == 4'hF) ? pc_plus8 : rf[ra1];
  assign rd2 = (ra2 == 4'hF) ? pc_plus8 : rf[ra2];

  always_comb begin
    ext_imm = '0;
    case (ImmSrc)
`ifdef DATAPATH_ROTIMM_EN
      2'b00:   ext_imm = rot_imm(Instr[11:0]);
`else
      2'b00:   ext_imm = {24'b0, Instr[7:0]};
`endif
      2'b01:   ext_imm = {20'b0, Instr[11:0]};
      2'b10:   ext_imm = $signed({Instr[23:0], 2'b00}) >>> 0;
      default: ext_imm = '0;
    endcase
    if (ImmSrc == 2'b10)
      ext_imm = {{6{Instr[23]}}, Instr[23:0], 2'b00};
  end

  assign src_b   = ALUSrc ? ext_imm : rd2;
  assign alu_out = alu(rd1, src_b, ALUControl);

  assign ALUResult = alu_out[31:0];
  assign Negative  = alu_out[35];
  assign Zero      = alu_out[34];
  assign Carry     = alu_out[33];
  assign Overflow  = alu_out[32];
  assign WriteData = rd2;

  assign result  = MemtoReg ? ReadData : ALUResult;
  assign pc_next = PCSrc ? result : pc_plus4;

  assign unused_instr = ^Instr[31:24];

  // State: PC and R0..R14; R15 exists only as the PC, so writes to it are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC <= '0;
      for (int i = 0; i < 15; i++) rf[i] <= '0;
    end else begin
      PC <= pc_next;
      if (RegWrite && (wa3 != 4'hF)) rf[wa3] <= result;
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_data_path;

  logic        clk, reset;
  logic [1:0]  RegSrc, ImmSrc, ALUControl;
  logic        RegWrite, ALUSrc, MemtoReg, PCSrc;
  logic        Zero, Negative, Overflow, Carry;
  logic [31:0] PC, Instr, ALUResult, WriteData, ReadData;

  data_path dut (
    .clk(clk), .reset(reset), .RegSrc(RegSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc),
    .ALUSrc(ALUSrc), .ALUControl(ALUControl), .MemtoReg(MemtoReg), .PCSrc(PCSrc),
    .Zero(Zero), .Negative(Negative), .Overflow(Overflow), .Carry(Carry), .PC(PC),
    .Instr(Instr), .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData)
  );

  typedef struct packed {
    logic [7:0]  tag;
    logic [1:0]  sel;
    logic [31:0] val;
  } exp_t;

  localparam logic [1:0] S_PC = 2'd0, S_ALU = 2'd1, S_WD = 2'd2, S_FLG = 2'd3;

`ifdef DATAPATH_ROTIMM_EN
  localparam logic [31:0] IMM_A = 32'hE2000000;
  localparam logic [31:0] FLG_A = 32'h8;
`else
  localparam logic [31:0] IMM_A = 32'h000000E2;
  localparam logic [31:0] FLG_A = 32'h0;
`endif

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] actual(input logic [1:0] sel);
    case (sel)
      S_PC:    return PC;
      S_ALU:   return ALUResult;
      S_WD:    return WriteData;
      default: return {28'b0, Negative, Zero, Carry, Overflow};
    endcase
  endfunction

  function automatic string nm(input logic [1:0] sel);
    case (sel)
      S_PC:    return "pc";
      S_ALU:   return "alu_result";
      S_WD:    return "write_data";
      default: return "flags_nzcv";
    endcase
  endfunction

  task automatic drive(input logic [1:0] rs, input logic rw, input logic [1:0] is,
                       input logic as, input logic [1:0] ac, input logic m2r,
                       input logic ps, input logic [31:0] ins, input logic [31:0] rdat);
    RegSrc = rs; RegWrite = rw; ImmSrc = is; ALUSrc = as; ALUControl = ac;
    MemtoReg = m2r; PCSrc = ps; Instr = ins; ReadData = rdat;
  endtask

  task automatic expect_out(input logic [7:0] tag, input logic [1:0] sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    exp_t it;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        it  = q.pop_front();
        act = actual(it.sel);
        checks++;
        if (act !== it.val) begin
          errors++;
          $display("FAIL %s step=%0d got=%h want=%h", nm(it.sel), it.tag, act, it.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog step=0 got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    // Held in reset while trying to load R8 from ReadData
    drive(2'b00, 1'b1, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 32'h00088000, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #1;
    expect_out(0, S_PC, 32'h0);
    expect_out(0, S_ALU, 32'h0);
    expect_out(0, S_WD, 32'h0);
    expect_out(0, S_FLG, 32'h4);
    step();
    reset = 1'b1;

    drive(2'b00, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 32'h034084E2, 32'h0);
    expect_out(1, S_PC, 32'h0);
    expect_out(1, S_ALU, IMM_A);
    expect_out(1, S_FLG, FLG_A);
    step();

    drive(2'b00, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 32'h00080000, 32'h0);
    expect_out(2, S_PC, 32'h4);
    expect_out(2, S_ALU, IMM_A);
    step();

    drive(2'b01, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 32'h00000000, 32'h0);
    expect_out(3, S_PC, 32'h8);
    expect_out(3, S_ALU, 32'h10);
    step();

    drive(2'b00, 1'b1, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 32'h00001000, 32'h5);
    expect_out(4, S_PC, 32'hC);
    step();
    drive(2'b00, 1'b1, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 32'h00002000, 32'h5);
    step();

    drive(2'b00, 1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 1'b0, 32'h00010002, 32'h0);
    expect_out(6, S_PC, 32'h14);
    expect_out(6, S_ALU, 32'h0);
    expect_out(6, S_FLG, 32'h6);
    expect_out(6, S_WD, 32'h5);
    step();

    drive(2'b00, 1'b1, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 32'h00001000, 32'h7FFFFFFF);
    step();
    drive(2'b00, 1'b1, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 32'h00002000, 32'hFFFFFFFF);
    step();

    // Branch back to itself: (0x20+8) + (-8)
    drive(2'b01, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b1, 32'h0AFFFFFE, 32'h0);
    expect_out(9, S_PC, 32'h20);
    expect_out(9, S_ALU, 32'h20);
    expect_out(9, S_FLG, 32'h2);
    step();

    drive(2'b00, 1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 1'b0, 32'h00010002, 32'h0);
    expect_out(10, S_PC, 32'h20);
    expect_out(10, S_ALU, 32'h80000000);
    expect_out(10, S_FLG, 32'h9);
    expect_out(10, S_WD, 32'hFFFFFFFF);
    step();

    // Load into R9 while reading R9: old value seen this cycle
    drive(2'b00, 1'b1, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 32'h00099000, 32'hDEADBEEF);
    expect_out(11, S_PC, 32'h24);
    expect_out(11, S_ALU, 32'h0);
    expect_out(11, S_FLG, 32'h4);
    step();

    drive(2'b00, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 32'h00090000, 32'h0);
    expect_out(12, S_ALU, 32'hDEADBEEF);
    expect_out(12, S_FLG, 32'h8);
    step();

    drive(2'b00, 1'b1, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 32'h0000F000, 32'h12345678);
    expect_out(13, S_PC, 32'h2C);
    step();

    drive(2'b11, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0000F000, 32'h0);
    expect_out(14, S_PC, 32'h30);
    expect_out(14, S_ALU, 32'h38);
    expect_out(14, S_WD, 32'h38);
    step();

    // Asynchronous reset mid-run clears PC and registers
    reset = 1'b0;
    drive(2'b00, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 32'h00080000, 32'h0);
    #1;
    expect_out(15, S_PC, 32'h0);
    expect_out(15, S_ALU, 32'h0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain step=16 got=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
